// File: rtl/slt_compare_scheduler_if.sv
// Request/response bundle for the shared set-less-than engine.
// Two requesters present operand pairs; one response channel returns
// the SLT word together with the id of the requester that owns it.
interface slt_compare_scheduler_if #(
  parameter int WIDTH = 32
);
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic             req0_signed;

  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic             req1_signed;

  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [WIDTH-1:0] rsp_result;

  logic             busy;

  // Requesters and the response consumer.
  modport master (
    output req0_valid, req0_a, req0_b, req0_signed,
    output req1_valid, req1_a, req1_b, req1_signed,
    output rsp_ready,
    input  req0_ready, req1_ready, rsp_valid, rsp_id, rsp_result, busy
  );

  // The compare engine.
  modport slave (
    input  req0_valid, req0_a, req0_b, req0_signed,
    input  req1_valid, req1_a, req1_b, req1_signed,
    input  rsp_ready,
    output req0_ready, req1_ready, rsp_valid, rsp_id, rsp_result, busy
  );
endinterface

// File: rtl/slt_compare_scheduler.sv
// Multi-cycle set-less-than engine shared by two requesters.
// Round-robin grant in IDLE, then one SLICE-bit slice compared per cycle
// from the MSB down with early exit on the first unequal slice. Signed
// compares flip the sign bit of both operands at capture so that every
// slice can use a plain unsigned compare.
module slt_compare_scheduler #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input logic                   clk,
  input logic                   reset,
  slt_compare_scheduler_if.slave bus
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [WIDTH-1:0] SIGN_MASK = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [IDXW-1:0]  TOP_IDX   = IDXW'(NSLICE - 1);
  localparam logic [IDXW-1:0]  ZERO_IDX  = {IDXW{1'b0}};

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPARE = 2'd1,
    RESPOND = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_next_s;
  logic             last_grant_r;
  logic             grant_valid_s;
  logic             grant_s;
  logic [WIDTH-1:0] sel_a_s;
  logic [WIDTH-1:0] sel_b_s;
  logic             sel_signed_s;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic             id_r;
  logic [IDXW-1:0]  idx_r;
  logic [SLICE-1:0] a_slice_s;
  logic [SLICE-1:0] b_slice_s;
  logic             slice_ne_s;
  logic             slice_lt_s;
  logic             decide_s;
  logic             less_r;
  logic             rsp_valid_r;
  logic             rsp_id_r;

  // Extract slice k of an operand (k = 0 is the least significant slice).
  function automatic logic [SLICE-1:0] slice_of(input logic [WIDTH-1:0] v,
                                                input logic [IDXW-1:0]  k);
    logic [WIDTH-1:0] sh;
    sh = v >> (32'(k) * 32'(SLICE));
    return sh[SLICE-1:0];
  endfunction

  // Round-robin grant: a lone requester wins, a tie goes away from last_grant.
  always_comb begin
    grant_valid_s = 1'b0;
    grant_s       = 1'b0;
    if ((state_r == IDLE) && !reset) begin
      if (bus.req0_valid && bus.req1_valid) begin
        grant_valid_s = 1'b1;
        grant_s       = ~last_grant_r;
      end else if (bus.req0_valid) begin
        grant_valid_s = 1'b1;
        grant_s       = 1'b0;
      end else if (bus.req1_valid) begin
        grant_valid_s = 1'b1;
        grant_s       = 1'b1;
      end else begin
        grant_valid_s = 1'b0;
        grant_s       = 1'b0;
      end
    end else begin
      grant_valid_s = 1'b0;
      grant_s       = 1'b0;
    end
  end

  assign bus.req0_ready = grant_valid_s & ~grant_s;
  assign bus.req1_ready = grant_valid_s &  grant_s;

  // Operand mux feeding the capture registers.
  always_comb begin
    sel_a_s      = bus.req0_a;
    sel_b_s      = bus.req0_b;
    sel_signed_s = bus.req0_signed;
    if (grant_s) begin
      sel_a_s      = bus.req1_a;
      sel_b_s      = bus.req1_b;
      sel_signed_s = bus.req1_signed;
    end else begin
      sel_a_s      = bus.req0_a;
      sel_b_s      = bus.req0_b;
      sel_signed_s = bus.req0_signed;
    end
  end

  // Current slice compare; a decision is made on inequality or at slice 0.
  always_comb begin
    a_slice_s  = slice_of(a_r, idx_r);
    b_slice_s  = slice_of(b_r, idx_r);
    slice_ne_s = (a_slice_s != b_slice_s);
    slice_lt_s = (a_slice_s <  b_slice_s);
    decide_s   = slice_ne_s || (idx_r == ZERO_IDX);
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (grant_valid_s) state_next_s = COMPARE;
        else               state_next_s = IDLE;
      end
      COMPARE: begin
        if (decide_s) state_next_s = RESPOND;
        else          state_next_s = COMPARE;
      end
      RESPOND: begin
        if (bus.rsp_ready) state_next_s = IDLE;
        else               state_next_s = RESPOND;
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Datapath: operand capture, slice walk, and the registered response.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_r          <= {WIDTH{1'b0}};
      b_r          <= {WIDTH{1'b0}};
      id_r         <= 1'b0;
      idx_r        <= ZERO_IDX;
      last_grant_r <= 1'b1;
      less_r       <= 1'b0;
      rsp_valid_r  <= 1'b0;
      rsp_id_r     <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (grant_valid_s) begin
            a_r          <= sel_signed_s ? (sel_a_s ^ SIGN_MASK) : sel_a_s;
            b_r          <= sel_signed_s ? (sel_b_s ^ SIGN_MASK) : sel_b_s;
            id_r         <= grant_s;
            last_grant_r <= grant_s;
            idx_r        <= TOP_IDX;
          end
        end
        COMPARE: begin
          if (decide_s) begin
            less_r      <= slice_ne_s & slice_lt_s;
            rsp_valid_r <= 1'b1;
            rsp_id_r    <= id_r;
          end else begin
            idx_r <= idx_r - {{(IDXW-1){1'b0}}, 1'b1};
          end
        end
        RESPOND: begin
          if (bus.rsp_ready) rsp_valid_r <= 1'b0;
        end
        default: begin
          rsp_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.rsp_valid  = rsp_valid_r;
  assign bus.rsp_id     = rsp_id_r;
  assign bus.rsp_result = {{(WIDTH-1){1'b0}}, less_r};
  assign bus.busy       = (state_r != IDLE);

endmodule

// File: tb/tb_slt_compare_scheduler.sv
// Self-checking bench for slt_compare_scheduler: a negedge monitor pushes
// expected results on each accept and pops/compares on each response.
module tb_slt_compare_scheduler;

  localparam int WIDTH = 32;
  localparam int SLICE = 8;
  localparam int NS    = WIDTH / SLICE;

  logic clk;
  logic reset;
  int   cyc;
  int   acc_cyc;
  int   n_checks;
  int   n_pass;

  typedef struct {
    logic             id;
    logic [WIDTH-1:0] res;
    int               lat;
  } exp_t;

  exp_t q[$];
  logic grant_log[$];
  logic prev_valid;
  logic held_id;
  logic [WIDTH-1:0] held_res;

  slt_compare_scheduler_if #(.WIDTH(WIDTH)) bus();

  slt_compare_scheduler #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [WIDTH-1:0] got,
                       input logic [WIDTH-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic exp_less(input logic [WIDTH-1:0] a,
                                    input logic [WIDTH-1:0] b, input logic s);
    if (s) return ($signed(a) < $signed(b));
    else   return (a < b);
  endfunction

  // Sign flipping touches both operands equally, so the deciding slice is
  // simply the highest slice where the raw operands differ.
  function automatic int exp_lat(input logic [WIDTH-1:0] a,
                                 input logic [WIDTH-1:0] b);
    for (int k = NS - 1; k >= 0; k--)
      if (a[k*SLICE +: SLICE] != b[k*SLICE +: SLICE]) return NS - k;
    return NS;
  endfunction

  function automatic exp_t mk(input logic id, input logic [WIDTH-1:0] a,
                              input logic [WIDTH-1:0] b, input logic s);
    exp_t e;
    e.id  = id;
    e.res = {{(WIDTH-1){1'b0}}, exp_less(a, b, s)};
    e.lat = exp_lat(a, b);
    return e;
  endfunction

  // Monitor: scoreboard push on accept, compare on response, protocol checks.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.req0_ready || bus.req1_ready) begin
        check("one_ready", {31'd0, bus.req0_ready & bus.req1_ready}, 32'd0);
        check("ready_only_idle", {31'd0, bus.busy}, 32'd0);
      end
      if (bus.req0_valid && bus.req0_ready) begin
        q.push_back(mk(1'b0, bus.req0_a, bus.req0_b, bus.req0_signed));
        grant_log.push_back(1'b0);
        acc_cyc = cyc + 1;
      end else if (bus.req1_valid && bus.req1_ready) begin
        q.push_back(mk(1'b1, bus.req1_a, bus.req1_b, bus.req1_signed));
        grant_log.push_back(1'b1);
        acc_cyc = cyc + 1;
      end
      if (bus.rsp_valid && !prev_valid) begin
        if (q.size() == 0) check("spurious_rsp", {31'd0, bus.rsp_valid}, 32'd0);
        else check("latency", cyc - acc_cyc, q[0].lat);
      end
      if (bus.rsp_valid) begin
        check("busy_in_respond", {31'd0, bus.busy}, 32'd1);
        check("no_ready_in_respond", {31'd0, bus.req0_ready | bus.req1_ready}, 32'd0);
        if (prev_valid) begin
          check("hold_id", {31'd0, bus.rsp_id}, {31'd0, held_id});
          check("hold_result", bus.rsp_result, held_res);
        end
      end
      if (bus.rsp_valid && bus.rsp_ready && q.size() > 0) begin
        exp_t e;
        e = q.pop_front();
        check("rsp_id", {31'd0, bus.rsp_id}, {31'd0, e.id});
        check("rsp_result", bus.rsp_result, e.res);
      end
      prev_valid = bus.rsp_valid;
      held_id    = bus.rsp_id;
      held_res   = bus.rsp_result;
    end else begin
      prev_valid = 1'b0;
    end
  end

  task automatic send(input int n, input logic [WIDTH-1:0] a,
                      input logic [WIDTH-1:0] b, input logic s);
    int   cnt;
    logic acc;
    if (n == 0) begin
      bus.req0_a = a; bus.req0_b = b; bus.req0_signed = s; bus.req0_valid = 1'b1;
    end else begin
      bus.req1_a = a; bus.req1_b = b; bus.req1_signed = s; bus.req1_valid = 1'b1;
    end
    acc = 1'b0;
    cnt = 0;
    while (!acc && cnt < 50) begin
      @(negedge clk);
      acc = (n == 0) ? bus.req0_ready : bus.req1_ready;
      @(posedge clk);
      #1;
      cnt++;
    end
    if (n == 0) bus.req0_valid = 1'b0;
    else        bus.req1_valid = 1'b0;
    check("accepted", {31'd0, acc}, 32'd1);
  endtask

  task automatic wait_idle();
    int cnt;
    cnt = 0;
    while ((q.size() != 0 || bus.busy) && cnt < 60) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    check("drained", {31'd0, (q.size() == 0) && !bus.busy}, 32'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rsp_valid"},  {31'd0, bus.rsp_valid}, 32'd0);
    check({tag, "_rsp_id"},     {31'd0, bus.rsp_id}, 32'd0);
    check({tag, "_rsp_result"}, bus.rsp_result, 32'd0);
    check({tag, "_readies"},    {31'd0, bus.req0_ready | bus.req1_ready}, 32'd0);
    check({tag, "_busy"},       {31'd0, bus.busy}, 32'd0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    int cnt;
    n_checks = 0; n_pass = 0; cyc = 0; acc_cyc = 0; prev_valid = 1'b0;
    held_id = 1'b0; held_res = '0;
    reset = 1'b1;
    bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_signed = 1'b0;
    bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_signed = 1'b0;
    bus.rsp_ready = 1'b1;
    #1;
    check_all_zero("reset");
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;

    // Arbitration: both held valid, expect grant order 0,1,0,1.
    fork
      send(0, 32'd10, 32'd20, 1'b0);
      send(1, 32'd30, 32'd5, 1'b0);
    join
    wait_idle();
    fork
      send(0, 32'hFFFF_0000, 32'h0000_0001, 1'b1);
      send(1, 32'h0000_1234, 32'h0000_1234, 1'b0);
    join
    wait_idle();
    check("grant_count", grant_log.size(), 32'd4);
    for (int i = 0; i < grant_log.size() && i < 4; i++)
      check($sformatf("grant_order_%0d", i), {31'd0, grant_log[i]}, i % 2);

    // Directed operand patterns.
    send(0, 32'd4294000000, 32'd4294000001, 1'b0); wait_idle();
    send(0, 32'd4294000001, 32'd4294000000, 1'b0); wait_idle();
    send(1, 32'd4294000001, 32'd4294000000, 1'b1); wait_idle();
    send(0, 32'd12, 32'd21, 1'b0);                 wait_idle();
    send(1, 32'hFFFF_FFFF, 32'd1, 1'b1);           wait_idle();
    send(0, 32'hFFFF_FFFF, 32'd1, 1'b0);           wait_idle();
    send(1, 32'h8000_0000, 32'h8000_0000, 1'b1);   wait_idle();
    send(0, 32'h8000_0000, 32'h8000_0000, 1'b0);   wait_idle();

    // Random operand pairs, half of them differing in a single bit.
    for (int i = 0; i < 16; i++) begin
      ra = $urandom;
      if ($urandom_range(0, 1) == 1) rb = ra ^ (32'd1 << $urandom_range(0, 31));
      else                           rb = $urandom;
      send(i % 2, ra, rb, 1'($urandom_range(0, 1)));
      wait_idle();
    end

    // Backpressure: hold rsp_ready low for 5 cycles while req0 waits.
    bus.rsp_ready = 1'b0;
    send(1, 32'd7, 32'd3, 1'b0);
    cnt = 0;
    while (!bus.rsp_valid && cnt < 20) begin
      @(posedge clk); #1; cnt++;
    end
    check("bp_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
    fork
      send(0, 32'd1, 32'd2, 1'b0);
    join_none
    repeat (5) @(posedge clk);
    #1;
    check("bp_still_valid", {31'd0, bus.rsp_valid}, 32'd1);
    check("bp_busy", {31'd0, bus.busy}, 32'd1);
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_idle_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    check("bp_idle_busy", {31'd0, bus.busy}, 32'd0);
    wait fork;
    wait_idle();

    // Reset two cycles after accept drops the operation.
    send(0, 32'h1111_1111, 32'h1111_1111, 1'b0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    check_all_zero("midreset");
    q.delete();
    grant_log.delete();
    @(posedge clk); #1 reset = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("no_rsp_after_reset", {31'd0, bus.rsp_valid}, 32'd0);
    fork
      send(0, 32'd3, 32'd4, 1'b0);
      send(1, 32'd4, 32'd3, 1'b0);
    join
    wait_idle();
    check("post_reset_grants", grant_log.size(), 32'd2);
    if (grant_log.size() > 0)
      check("post_reset_first_grant", {31'd0, grant_log[0]}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
